pixel_stream_tx: RTL and testbench

//  Output-side transmitter for the grayscale/Sobel pipeline: accepts processed pixels on the
//  px_rdy strobe interface, buffers them in a small FIFO and streams them off-chip as bytes

---
 rtl/pixel_stream_tx.sv | 186 ++++++++++++++++++
 tb/tb_pixel_stream_tx.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_tx.sv
// Pixel-to-byte transmitter: buffers pipeline pixels in a small FIFO and streams
// them as 1 or 3 bytes per pixel over a valid/ready handshake.
module pixel_stream_tx #(
   parameter int PIXEL_BITS = 24,
   parameter int LANE_BITS  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          px_rdy_i,
   input  logic [PIXEL_BITS-1:0]         in_pixel_i,
   input  logic                          byte_mode_i,
   input  logic                          clear_ovf_i,
   output logic [LANE_BITS-1:0]          data_o,
   output logic                          valid_o,
   input  logic                          ready_i,
   output logic                          last_o,
   output logic                          overflow_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = PIXEL_BITS + 1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   logic [EW-1:0]         r_mem [FIFO_DEPTH];
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;
   state_t                r_state;
   state_t                w_state_nxt;
   logic [PIXEL_BITS-1:0] r_pixel;
   logic [PIXEL_BITS-1:0] w_pixel_nxt;
   logic [1:0]            r_idx;
   logic [1:0]            w_idx_nxt;
   logic [1:0]            w_idx_inc;
   logic [LANE_BITS-1:0]  r_data;
   logic [LANE_BITS-1:0]  w_data_nxt;
   logic                  r_valid;
   logic                  w_valid_nxt;
   logic                  r_last;
   logic                  w_last_nxt;
   logic                  r_ovf;
   logic                  w_hs;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_drop;
   logic                  w_not_empty;
   logic                  w_not_full;
   logic [EW-1:0]         w_head;

   // Byte idx of a 3-byte pixel, most significant lane first.
   function automatic logic [LANE_BITS-1:0] lane_sel(input logic [PIXEL_BITS-1:0] pix,
                                                     input logic [1:0] idx);
      logic [LANE_BITS-1:0] res;
      case (idx)
         2'd0:    res = pix[PIXEL_BITS-1 -: LANE_BITS];
         2'd1:    res = pix[2*LANE_BITS-1 -: LANE_BITS];
         default: res = pix[LANE_BITS-1:0];
      endcase
      return res;
   endfunction

   assign w_hs        = r_valid && ready_i;
   assign w_not_empty = (r_count != {CW{1'b0}});
   assign w_not_full  = (r_count < CW'(FIFO_DEPTH));
   assign w_head      = r_mem[r_rd_ptr];
   assign w_idx_inc   = r_idx + 2'd1;
   assign w_push      = px_rdy_i && (w_not_full || w_pop);
   assign w_drop      = px_rdy_i && !w_push;

   // Next-state and next-output decode; a pop loads the head pixel for sending.
   always_comb begin
      w_state_nxt = r_state;
      w_pixel_nxt = r_pixel;
      w_idx_nxt   = r_idx;
      w_data_nxt  = r_data;
      w_valid_nxt = r_valid;
      w_last_nxt  = r_last;
      w_pop       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_not_empty) begin
               w_pop = 1'b1;
            end else begin
               w_valid_nxt = 1'b0;
               w_data_nxt  = {LANE_BITS{1'b0}};
               w_last_nxt  = 1'b0;
            end
         end
         ST_SEND: begin
            if (w_hs) begin
               if (r_last) begin
                  if (w_not_empty) begin
                     w_pop = 1'b1;
                  end else begin
                     w_state_nxt = ST_IDLE;
                     w_valid_nxt = 1'b0;
                     w_data_nxt  = {LANE_BITS{1'b0}};
                     w_last_nxt  = 1'b0;
                  end
               end else begin
                  w_idx_nxt  = w_idx_inc;
                  w_data_nxt = lane_sel(r_pixel, w_idx_inc);
                  w_last_nxt = (w_idx_inc == 2'd2);
               end
            end else begin
               w_valid_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
            w_data_nxt  = {LANE_BITS{1'b0}};
            w_last_nxt  = 1'b0;
         end
      endcase
      if (w_pop) begin
         w_state_nxt = ST_SEND;
         w_pixel_nxt = w_head[PIXEL_BITS-1:0];
         w_idx_nxt   = 2'd0;
         w_valid_nxt = 1'b1;
         w_last_nxt  = w_head[PIXEL_BITS];
         w_data_nxt  = w_head[PIXEL_BITS] ? w_head[LANE_BITS-1:0] : lane_sel(w_head[PIXEL_BITS-1:0], 2'd0);
      end else begin
         w_idx_nxt = w_idx_nxt;
      end
   end

   // FSM state and registered output byte, valid and last.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state <= ST_IDLE;
         r_pixel <= {PIXEL_BITS{1'b0}};
         r_idx   <= 2'd0;
         r_data  <= {LANE_BITS{1'b0}};
         r_valid <= 1'b0;
         r_last  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pixel <= w_pixel_nxt;
         r_idx   <= w_idx_nxt;
         r_data  <= w_data_nxt;
         r_valid <= w_valid_nxt;
         r_last  <= w_last_nxt;
      end
   end

   // FIFO pointers, occupancy and sticky overflow (a drop beats a clear).
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_wr_ptr <= {PW{1'b0}};
         r_rd_ptr <= {PW{1'b0}};
         r_count  <= {CW{1'b0}};
         r_ovf    <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1'b1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1'b1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1'b1);
            2'b01:   r_count <= r_count - CW'(1'b1);
            default: r_count <= r_count;
         endcase
         if (w_drop)           r_ovf <= 1'b1;
         else if (clear_ovf_i) r_ovf <= 1'b0;
         else                  r_ovf <= r_ovf;
      end
   end

   // FIFO storage; contents are don't-care while the count says empty.
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr] <= {byte_mode_i, in_pixel_i};
   end

   assign data_o       = r_data;
   assign valid_o      = r_valid;
   assign last_o       = r_last;
   assign overflow_o   = r_ovf;
   assign fifo_count_o = r_count;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Directed self-checking bench for pixel_stream_tx: latency, byte order, stalls,
// overflow, full-FIFO push on last byte and mid-pixel reset.
module tb_pixel_stream_tx;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        px_rdy_i = 1'b0;
   logic [23:0] in_pixel_i = 24'h0;
   logic        byte_mode_i = 1'b0;
   logic        clear_ovf_i = 1'b0;
   logic [7:0]  data_o;
   logic        valid_o;
   logic        ready_i = 1'b0;
   logic        last_o;
   logic        overflow_o;
   logic [2:0]  fifo_count_o;

   int n_checks = 0;
   int n_errors = 0;

   pixel_stream_tx #(.PIXEL_BITS(24), .LANE_BITS(8), .FIFO_DEPTH(4)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .px_rdy_i(px_rdy_i), .in_pixel_i(in_pixel_i),
      .byte_mode_i(byte_mode_i), .clear_ovf_i(clear_ovf_i), .data_o(data_o),
      .valid_o(valid_o), .ready_i(ready_i), .last_o(last_o), .overflow_o(overflow_o),
      .fifo_count_o(fifo_count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic exp_out(input string tag, input logic v, input logic [7:0] d, input logic l);
      check_eq({tag, ".valid"}, {31'd0, valid_o}, {31'd0, v});
      check_eq({tag, ".data"},  {24'd0, data_o},  {24'd0, d});
      check_eq({tag, ".last"},  {31'd0, last_o},  {31'd0, l});
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [23:0] pk(input int k);
      logic [7:0] kb;
      kb = k[7:0];
      return {8'h10 + kb, 8'h20 + kb, 8'h30 + kb};
   endfunction

   int ks[5] = '{2, 3, 4, 5, 7};

   initial begin
      // Reset state
      step(); step(); step();
      exp_out("rst", 1'b0, 8'h00, 1'b0);
      check_eq("rst.count", {29'd0, fifo_count_o}, 32'd0);
      check_eq("rst.ovf", {31'd0, overflow_o}, 32'd0);
      reset_i = 1'b0;
      ready_i = 1'b1;

      // 1: three-byte pixel, latency N+2
      px_rdy_i = 1'b1; in_pixel_i = 24'hA1B2C3; byte_mode_i = 1'b0;
      step();
      px_rdy_i = 1'b0;
      exp_out("t1.n1", 1'b0, 8'h00, 1'b0);
      check_eq("t1.n1.count", {29'd0, fifo_count_o}, 32'd1);
      step(); exp_out("t1.b0", 1'b1, 8'hA1, 1'b0);
      check_eq("t1.b0.count", {29'd0, fifo_count_o}, 32'd0);
      step(); exp_out("t1.b1", 1'b1, 8'hB2, 1'b0);
      step(); exp_out("t1.b2", 1'b1, 8'hC3, 1'b1);
      step(); exp_out("t1.idle", 1'b0, 8'h00, 1'b0);

      // 2: byte mode sends only the low byte
      px_rdy_i = 1'b1; in_pixel_i = 24'h123456; byte_mode_i = 1'b1;
      step();
      px_rdy_i = 1'b0; byte_mode_i = 1'b0;
      exp_out("t2.n1", 1'b0, 8'h00, 1'b0);
      step(); exp_out("t2.b0", 1'b1, 8'h56, 1'b1);
      step(); exp_out("t2.idle", 1'b0, 8'h00, 1'b0);

      // 3: stall mid-pixel holds outputs
      ready_i = 1'b0;
      px_rdy_i = 1'b1; in_pixel_i = 24'h0A0B0C;
      step();
      px_rdy_i = 1'b0;
      step(); exp_out("t3.b0", 1'b1, 8'h0A, 1'b0);
      ready_i = 1'b1;
      step(); exp_out("t3.b1", 1'b1, 8'h0B, 1'b0);
      ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(); exp_out($sformatf("t3.hold%0d", i), 1'b1, 8'h0B, 1'b0);
      end
      ready_i = 1'b1;
      step(); exp_out("t3.b2", 1'b1, 8'h0C, 1'b1);
      step(); exp_out("t3.idle", 1'b0, 8'h00, 1'b0);

      // 4: fill FIFO with downstream stalled; one pixel sits in the shifter, 6th is dropped
      ready_i = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         px_rdy_i = 1'b1; in_pixel_i = pk(k);
         step();
      end
      px_rdy_i = 1'b0;
      check_eq("t4.count", {29'd0, fifo_count_o}, 32'd4);
      check_eq("t4.ovf", {31'd0, overflow_o}, 32'd1);
      exp_out("t4.head", 1'b1, 8'h11, 1'b0);
      clear_ovf_i = 1'b1;
      step();
      clear_ovf_i = 1'b0;
      check_eq("t4.ovf_clr", {31'd0, overflow_o}, 32'd0);

      // 5: push into full FIFO on the last-byte handshake is accepted
      ready_i = 1'b1;
      step(); exp_out("t5.p1b1", 1'b1, 8'h21, 1'b0);
      step(); exp_out("t5.p1b2", 1'b1, 8'h31, 1'b1);
      px_rdy_i = 1'b1; in_pixel_i = pk(7);
      step();
      px_rdy_i = 1'b0;
      check_eq("t5.count", {29'd0, fifo_count_o}, 32'd4);
      check_eq("t5.ovf", {31'd0, overflow_o}, 32'd0);
      for (int p = 0; p < 5; p++) begin
         for (int b = 0; b < 3; b++) begin
            logic [23:0] px;
            px = pk(ks[p]);
            exp_out($sformatf("t5.drain%0d_%0d", p, b), 1'b1, px[23-8*b -: 8], (b == 2));
            step();
         end
      end
      exp_out("t5.idle", 1'b0, 8'h00, 1'b0);
      check_eq("t5.empty", {29'd0, fifo_count_o}, 32'd0);

      // 6: reset after the second byte abandons the pixel and flushes the FIFO
      px_rdy_i = 1'b1; in_pixel_i = 24'hC0FFEE;
      step();
      px_rdy_i = 1'b0;
      step(); exp_out("t6.b0", 1'b1, 8'hC0, 1'b0);
      px_rdy_i = 1'b1; in_pixel_i = 24'h445566;
      step();
      px_rdy_i = 1'b0;
      exp_out("t6.b1", 1'b1, 8'hFF, 1'b0);
      check_eq("t6.count_pre", {29'd0, fifo_count_o}, 32'd1);
      reset_i = 1'b1; ready_i = 1'b0;
      step();
      reset_i = 1'b0; ready_i = 1'b1;
      exp_out("t6.rst", 1'b0, 8'h00, 1'b0);
      check_eq("t6.rst.count", {29'd0, fifo_count_o}, 32'd0);
      px_rdy_i = 1'b1; in_pixel_i = 24'h778899;
      step();
      px_rdy_i = 1'b0;
      exp_out("t6.n1", 1'b0, 8'h00, 1'b0);
      step(); exp_out("t6.nb0", 1'b1, 8'h77, 1'b0);
      step(); exp_out("t6.nb1", 1'b1, 8'h88, 1'b0);
      step(); exp_out("t6.nb2", 1'b1, 8'h99, 1'b1);
      step(); exp_out("t6.idle", 1'b0, 8'h00, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
